key_debounce: RTL and testbench

Front-end conditioning stage for the stopwatch push-buttons. It synchronises a raw, bouncing mechanical key input into the Clk domain and filters it with a stability counter. It produces a clean debounced level and single-cycle press/release strobes. Its key_level output drives the downstream rising-edge toggle detector; key_press is available for logic that wants a strobe directly.

---
 rtl/key_debounce_if.sv | 21 ++
 rtl/key_debounce.sv | 117 +++++++++++
 tb/tb_key_debounce.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Button-side signal bundle for the key debouncer: raw pin in, cleaned level and strobes out.
interface key_debounce_if;
  logic key_raw;
  logic key_level;
  logic key_press;
  logic key_release;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces a mechanical key; emits a registered level plus one-cycle press/release strobes.
// Latency DEBOUNCE_CYCLES+1 edges from the first sampling edge; no backpressure, outputs are pure flops.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic         Clk,
  input  logic         rst,
  key_debounce_if.slave bus
);

  localparam int unsigned           CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  logic             w_k_in;
  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;

  // Normalise polarity so 1 always means pressed.
  assign w_k_in = bus.key_raw ^ ACTIVE_LOW;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= w_k_in;
      r_s2      <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_level_nxt = 1'b0;
        if (r_s2) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_CHK: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        w_level_nxt = 1'b1;
        if (!r_s2) begin
          w_state_nxt = RELEASE_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE_CHK: begin
        if (r_s2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: DUT A (active-low, 8 cycles) via hand-written sequences,
// DUT B (active-high, 2 cycles) via a per-cycle vector table.
module tb_key_debounce;

  logic Clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 Clk = ~Clk;

  key_debounce_if a_if ();
  key_debounce_if b_if ();

  key_debounce #(.DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1)) u_dut_a (
    .Clk (Clk),
    .rst (rst_a),
    .bus (a_if.slave)
  );

  key_debounce #(.DEBOUNCE_CYCLES(2), .ACTIVE_LOW(1'b0)) u_dut_b (
    .Clk (Clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       raw;
    logic [2:0] exp;   // {level, press, release} after the following edge
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply raw for n cycles; level must stay at exp_level with no strobes.
  task automatic quiet(input string name, input logic raw, input int n, input logic exp_level);
    int bad = 0;
    a_if.key_raw = raw;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      if (a_if.key_level !== exp_level || a_if.key_press !== 1'b0 || a_if.key_release !== 1'b0)
        bad++;
    end
    check(name, bad, 0);
  endtask

  // Apply raw before edge E0 and report the edge index (relative to E0) of the first output change.
  task automatic measure(input string name, input logic raw, input int exp_idx, input logic exp_press);
    int   idx  = -1;
    logic prev = a_if.key_level;
    a_if.key_raw = raw;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (a_if.key_press || a_if.key_release || a_if.key_level !== prev) begin
        idx = k;
        break;
      end
    end
    check({name, "_edge"}, idx, exp_idx);
    check({name, "_outs"}, {a_if.key_level, a_if.key_press, a_if.key_release},
          exp_press ? 3'b110 : 3'b001);
  endtask

  initial begin
    a_if.key_raw = 1'b1;
    b_if.key_raw = 1'b0;

    tbl[0]  = '{1'b0, 3'b000};  tbl[1]  = '{1'b0, 3'b000};
    tbl[2]  = '{1'b1, 3'b000};  tbl[3]  = '{1'b1, 3'b000};
    tbl[4]  = '{1'b1, 3'b000};  tbl[5]  = '{1'b1, 3'b110};
    tbl[6]  = '{1'b1, 3'b100};  tbl[7]  = '{1'b1, 3'b100};
    tbl[8]  = '{1'b0, 3'b100};  tbl[9]  = '{1'b1, 3'b100};
    tbl[10] = '{1'b1, 3'b100};  tbl[11] = '{1'b1, 3'b100};
    tbl[12] = '{1'b1, 3'b100};  tbl[13] = '{1'b0, 3'b100};
    tbl[14] = '{1'b0, 3'b100};  tbl[15] = '{1'b0, 3'b100};
    tbl[16] = '{1'b0, 3'b001};  tbl[17] = '{1'b0, 3'b000};
    tbl[18] = '{1'b0, 3'b000};  tbl[19] = '{1'b1, 3'b000};
    tbl[20] = '{1'b0, 3'b000};  tbl[21] = '{1'b0, 3'b000};
    tbl[22] = '{1'b0, 3'b000};  tbl[23] = '{1'b0, 3'b000};

    // Reset with the pull-up key idle.
    repeat (3) @(negedge Clk);
    check("rst_level",   a_if.key_level,   0);
    check("rst_press",   a_if.key_press,   0);
    check("rst_release", a_if.key_release, 0);
    rst_a = 1'b0;
    quiet("idle_100", 1'b1, 100, 1'b0);

    // Clean press and single-cycle strobe.
    measure("press", 1'b0, 9, 1'b1);
    @(negedge Clk);
    check("press_strobe_width", {a_if.key_level, a_if.key_press, a_if.key_release}, 3'b100);
    quiet("held_no_repeat", 1'b0, 20, 1'b1);

    // Release with a 4-cycle bounce back to pressed.
    quiet("rel_bounce_hi", 1'b1, 4, 1'b1);
    quiet("rel_bounce_lo", 1'b0, 4, 1'b1);
    measure("release", 1'b1, 9, 1'b0);
    quiet("released_stable", 1'b1, 10, 1'b0);

    // Glitch rejection: 7-cycle press is one short, then bounces before a clean press.
    quiet("short7_lo", 1'b0, 7, 1'b0);
    quiet("short7_hi", 1'b1, 10, 1'b0);
    quiet("bnc1_lo", 1'b0, 3, 1'b0);
    quiet("bnc1_hi", 1'b1, 2, 1'b0);
    quiet("bnc2_lo", 1'b0, 5, 1'b0);
    quiet("bnc2_hi", 1'b1, 2, 1'b0);
    quiet("bnc3_lo", 1'b0, 4, 1'b0);
    quiet("bnc3_hi", 1'b1, 3, 1'b0);
    measure("bounce_press", 1'b0, 9, 1'b1);
    quiet("bounce_single", 1'b0, 20, 1'b1);

    // Reset in the middle of a press qualification.
    measure("pre_rst_release", 1'b1, 9, 1'b0);
    a_if.key_raw = 1'b0;
    repeat (7) @(negedge Clk);
    rst_a = 1'b1;
    #1;
    check("midrst_outs", {a_if.key_level, a_if.key_press, a_if.key_release}, 3'b000);
    repeat (3) @(negedge Clk);
    check("midrst_hold_outs", {a_if.key_level, a_if.key_press, a_if.key_release}, 3'b000);
    rst_a = 1'b0;
    measure("post_rst_press", 1'b0, 9, 1'b1);

    // Reset acts without a clock edge.
    rst_a = 1'b1;
    #1;
    check("async_rst_level", a_if.key_level, 0);

    // Active-high, minimum debounce length.
    rst_b = 1'b0;
    for (int i = 0; i < 24; i++) begin
      b_if.key_raw = tbl[i].raw;
      @(negedge Clk);
      check($sformatf("vecB_%0d", i),
            {b_if.key_level, b_if.key_press, b_if.key_release}, tbl[i].exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
